const_div_seq: RTL and testbench

CONST_DIV_SEQ -- requirements
Module: const_div_seq

---
 rtl/const_div_seq.sv | 137 +++++++++++++
 tb/tb_const_div_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/const_div_seq.sv
// ---------------------------------------------------------------------------
// const_div_seq
//
// Sequential divider by a compile-time constant. It consumes the dividend
// CHUNK bits per clock, most significant chunk first. Each step replaces the
// divide with a constant lookup table indexed by {running remainder, chunk}.
// A result appears STEPS = WIDTH/CHUNK clock edges after the dividend is
// accepted, and stays on the outputs until the consumer takes it.
//
// Parameters:
//   WIDTH   : dividend and quotient width. It must be a multiple of CHUNK.
//   DIVISOR : constant divisor, 2 .. 2**CHUNK.
//   CHUNK   : dividend bits consumed per step.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   dividend offered
//   in_ready  out  block can accept a dividend (IDLE only)
//   dividend  in   WIDTH-bit unsigned dividend
//   out_valid out  result available (DONE only)
//   out_ready in   consumer accepts the result
//   quotient  out  floor(dividend / DIVISOR), 0 when out_valid is low
//   remainder out  dividend mod DIVISOR, 0 when out_valid is low
//   busy      out  high while running or holding a result
//
// Build option:
//   CONST_DIV_SEQ_REM_EN - when defined, the remainder port carries the final
//   running remainder in DONE. When it is undefined, the port is tied to 0.
// ---------------------------------------------------------------------------
module const_div_seq #(
   parameter int  WIDTH   = 32,
   parameter int  DIVISOR = 11,
   parameter int  CHUNK   = 4,
   localparam int RW      = $clog2(DIVISOR),
   localparam int STEPS   = WIDTH / CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [RW-1:0]    remainder,
   output logic             busy
);

   localparam int TN = 2 ** (RW + CHUNK);
   localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] quot_reg;
   logic [RW-1:0]    r_reg;
   logic [CW-1:0]    cnt_reg;

   // The table index {r, chunk} equals t = r*2^CHUNK + chunk. Each entry
   // therefore holds floor(t/DIVISOR) and t mod DIVISOR, both fixed at
   // elaboration time. Entries with r >= DIVISOR are never addressed.
   logic [CHUNK-1:0] q_tab [TN];
   logic [RW-1:0]    r_tab [TN];

   for (genvar gi = 0; gi < TN; gi++) begin : g_tab
      localparam int QV = gi / DIVISOR;
      localparam int RV = gi % DIVISOR;
      assign q_tab[gi] = QV[CHUNK-1:0];
      assign r_tab[gi] = RV[RW-1:0];
   end

   logic [RW+CHUNK-1:0] tab_idx;
   logic [CHUNK-1:0]    step_q;
   logic [RW-1:0]       step_r;
   logic                last_step;

   assign tab_idx   = {r_reg, shift_reg[WIDTH-1 -: CHUNK]};
   assign step_q    = q_tab[tab_idx];
   assign step_r    = r_tab[tab_idx];
   assign last_step = (cnt_reg == CW'(STEPS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         quot_reg  <= '0;
         r_reg     <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= dividend;
                  quot_reg  <= '0;
                  r_reg     <= '0;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               // Consume the top chunk and append its quotient digit at the LSB end.
               shift_reg <= shift_reg << CHUNK;
               quot_reg  <= (quot_reg << CHUNK) | WIDTH'(step_q);
               r_reg     <= step_r;
               cnt_reg   <= cnt_reg + 1'b1;
               if (last_step) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign quotient  = out_valid ? quot_reg : '0;

`ifdef CONST_DIV_SEQ_REM_EN
   assign remainder = out_valid ? r_reg : '0;
`else
   assign remainder = '0;
`endif

endmodule

// File: tb/tb_const_div_seq.sv
module tb_const_div_seq;

   localparam int WIDTH   = 32;
   localparam int DIVISOR = 11;
   localparam int CHUNK   = 4;
   localparam int RW      = 4;
   localparam int STEPS   = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [RW-1:0]    remainder;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   const_div_seq #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // The expected remainder follows the build option.
   function automatic longint exp_rem(input longint r);
`ifdef CONST_DIV_SEQ_REM_EN
      return r;
`else
      return 0;
`endif
   endfunction

   // ---------------- behavioural model ----------------
   // One job at most is in flight. A job's result is due STEPS edges after
   // the accept edge, and it is held until an edge with out_ready.
   bit     m_en   = 0;
   bit     m_pend = 0;
   longint cyc    = 0;
   longint m_due  = 0;
   longint m_div  = 0;
   longint m_q    = 0;
   longint m_r    = 0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_pend = 0;
      end else if (m_pend && cyc >= m_due && out_ready) begin
         $display("txn dividend=%0d quotient=%0d remainder=%0d", m_div, quotient, remainder);
         m_pend = 0;
      end else if (!m_pend && in_valid) begin
         m_pend = 1;
         m_due  = cyc + 1 + STEPS;
         m_div  = longint'(dividend);
         m_q    = m_div / DIVISOR;
         m_r    = m_div % DIVISOR;
      end
      cyc++;
   end

   // Compare process: checks the DUT on every falling edge once enabled.
   initial forever begin
      @(negedge clk);
      if (m_en) begin
         automatic bit v = m_pend && (cyc >= m_due);
         check("cmp_out_valid", longint'(out_valid), longint'(v));
         check("cmp_in_ready",  longint'(in_ready),  longint'(!m_pend));
         check("cmp_busy",      longint'(busy),      longint'(m_pend));
         check("cmp_quotient",  longint'(quotient),  v ? m_q : 0);
         check("cmp_remainder", longint'(remainder), v ? exp_rem(m_r) : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one dividend and checks its latency and result against literals.
   task automatic run_one(input logic [WIDTH-1:0] d, input longint eq, input longint er);
      int lat;
      dividend  = d;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("lit_latency",   lat, STEPS);
      check("lit_quotient",  longint'(quotient), eq);
      check("lit_remainder", longint'(remainder), exp_rem(er));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("lit_released", longint'(out_valid), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0;
      step(); step();
      in_valid = 1'b1;           // must not be accepted during reset
      dividend = 32'd77;
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("reset_in_ready",  longint'(in_ready), 1);
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_busy",      longint'(busy), 0);
      check("reset_quotient",  longint'(quotient), 0);
      check("reset_remainder", longint'(remainder), 0);
      m_en = 1;

      // Directed results.
      run_one(32'd1000, 90, 10);
      run_one(32'hFFFF_FFFF, 390451572, 3);
      run_one(32'd10, 0, 10);
      run_one(32'd0, 0, 0);

      // Result held in DONE for five cycles while in_valid pulses.
      dividend = 32'd1000; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (STEPS) step();
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         dividend = 32'd55;
         check("hold_out_valid", longint'(out_valid), 1);
         check("hold_in_ready",  longint'(in_ready), 0);
         check("hold_quotient",  longint'(quotient), 90);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("hold_idle_after_release", longint'(in_ready), 1);

      // Reset on the 4th RUN edge aborts the job.
      dividend = 32'd1000; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_out_valid", longint'(out_valid), 0);
      check("abort_busy",      longint'(busy), 0);
      check("abort_quotient",  longint'(quotient), 0);
      repeat (12) step();
      run_one(32'd121, 11, 0);

      // Random back-to-back traffic with random consumer stalls.
      for (int i = 0; i < 1500; i++) begin
         automatic int sel = $urandom_range(0, 9);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         dividend  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
                     (sel == 2) ? WIDTH'($urandom_range(0, 2 * DIVISOR)) : $urandom;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (STEPS + 2) step();
      check("drain_idle", longint'(in_ready), 1);

      m_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
